// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2 stride-2 signed max-pooling stage
//
// Purpose: takes feature-map pixels in raster order, one channel map after
// another, and emits one pooled pixel per 2x2 window. A one-cycle done pulse
// follows the last pooled pixel of a frame.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a frame (sampled only in IDLE)
//   in_valid   in_data carries a pixel this cycle
//   in_ready   high while the frame is being accepted (BUSY)
//   in_data    signed input pixel
//   out_valid  one-cycle strobe, out_data holds a pooled pixel
//   out_data   signed max of one 2x2 window
//   out_last   marks the final pooled pixel of the frame
//   done       one-cycle pulse, frame complete

module maxpool2x2_stream #(
  parameter int DATA_W   = 16,
  parameter int IMG_W    = 24,
  parameter int IMG_H    = 24,
  parameter int CHANNELS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  localparam int HALF_W = IMG_W / 2;
  localparam int COL_W  = (IMG_W > 1)    ? $clog2(IMG_W)    : 1;
  localparam int ROW_W  = (IMG_H > 1)    ? $clog2(IMG_H)    : 1;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IDX_W  = (HALF_W > 1)   ? $clog2(HALF_W)   : 1;

  // Windows must tile the map exactly.
  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
    $error("maxpool2x2_stream: IMG_W and IMG_H must be even and non-zero");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic [CH_W-1:0]     ch_q;
  logic [DATA_W-1:0]   hreg_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                done_q;

  // Holds the vertical partner of each window: max of the two even-row pixels.
  logic [DATA_W-1:0]   linebuf_q [HALF_W];

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic              xfer;
  logic              col_last;
  logic              row_last;
  logic              ch_last;
  logic              frame_last;
  logic [IDX_W-1:0]  lb_idx;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] horiz_max;
  logic [DATA_W-1:0] hreg_d;

  assign xfer       = (state_q == BUSY) && in_valid && in_ready_q;
  assign col_last   = (col_q == COL_W'(IMG_W - 1));
  assign row_last   = (row_q == ROW_W'(IMG_H - 1));
  assign ch_last    = (ch_q  == CH_W'(CHANNELS - 1));
  assign frame_last = col_last && row_last && ch_last;

  assign lb_idx    = IDX_W'(col_q >> 1);
  assign lb_rd     = linebuf_q[lb_idx];
  // Right-hand pixel folded with the left-hand partner held in hreg; used both
  // for the line-buffer write (even row) and the pooled result (odd row).
  assign horiz_max = smax(hreg_q, in_data);

  // Left-hand pixel of a window: raw on even rows, merged with the column
  // partner from the line buffer on odd rows.
  always_comb begin
    hreg_d = hreg_q;
    if (xfer && !col_q[0]) begin
      hreg_d = row_q[0] ? smax(lb_rd, in_data) : in_data;
    end
  end

  // Line buffer carries no reset: every entry is written on an even row before
  // the following odd row reads it.
  always_ff @(posedge clk) begin
    if (xfer && !row_q[0] && col_q[0]) begin
      linebuf_q[lb_idx] <= horiz_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      hreg_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      hreg_q      <= hreg_d;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= BUSY;
            in_ready_q <= 1'b1;
            col_q      <= '0;
            row_q      <= '0;
            ch_q       <= '0;
          end
        end

        BUSY: begin
          if (xfer) begin
            if (row_q[0] && col_q[0]) begin
              out_data_q  <= horiz_max;
              out_valid_q <= 1'b1;
              out_last_q  <= frame_last;
            end

            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                row_q <= '0;
                ch_q  <= ch_last ? '0 : ch_q + 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end

            if (frame_last) begin
              state_q    <= FLUSH;
              in_ready_q <= 1'b0;
            end
          end
        end

        FLUSH: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end

        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - bench for maxpool2x2_stream (4x4 maps, 1 and 2 channels)

module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start_a, in_valid_a, in_ready_a, out_valid_a, out_last_a, done_a;
  logic [15:0] in_data_a, out_data_a;
  logic        start_b, in_valid_b, in_ready_b, out_valid_b, out_last_b, done_b;
  logic [15:0] in_data_b, out_data_b;

  maxpool2x2_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .CHANNELS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .in_data(in_data_a), .out_valid(out_valid_a),
    .out_data(out_data_a), .out_last(out_last_a), .done(done_a)
  );

  maxpool2x2_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .CHANNELS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .in_data(in_data_b), .out_valid(out_valid_b),
    .out_data(out_data_b), .out_last(out_last_b), .done(done_b)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int               sel;
    int               n_px;
    int               duty;
    bit               mid_start;
    logic [31:0][15:0] px;
    logic [7:0][15:0]  exp_o;
  } vec_t;

  exp_t exp_q_a[$];
  exp_t exp_q_b[$];
  exp_t e_a, e_b;
  vec_t vecs[7];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int done_cnt[2];
  int done_cyc[2];
  int last_cyc[2];
  int out_cnt[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output scoreboards, sampled on the falling edge.
  always @(negedge clk) begin
    if (out_valid_a) begin
      out_cnt[0]++;
      if (out_last_a) last_cyc[0] = cyc;
      if (exp_q_a.size() == 0) check("unexpected out_valid dut_a", 1, 0);
      else begin
        e_a = exp_q_a.pop_front();
        check("out_data dut_a", int'($signed(out_data_a)), int'($signed(e_a.data)));
        check("out_last dut_a", int'(out_last_a), int'(e_a.last));
      end
    end
    if (done_a) begin
      done_cnt[0]++;
      done_cyc[0] = cyc;
      check("in_ready at done dut_a", int'(in_ready_a), 0);
    end
  end

  always @(negedge clk) begin
    if (out_valid_b) begin
      out_cnt[1]++;
      if (out_last_b) last_cyc[1] = cyc;
      if (exp_q_b.size() == 0) check("unexpected out_valid dut_b", 1, 0);
      else begin
        e_b = exp_q_b.pop_front();
        check("out_data dut_b", int'($signed(out_data_b)), int'($signed(e_b.data)));
        check("out_last dut_b", int'(out_last_b), int'(e_b.last));
      end
    end
    if (done_b) begin
      done_cnt[1]++;
      done_cyc[1] = cyc;
      check("in_ready at done dut_b", int'(in_ready_b), 0);
    end
  end

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask

  task automatic set_in(input int sel, input logic v, input logic [15:0] d);
    if (sel == 0) begin in_valid_a = v; in_data_a = d; end
    else          begin in_valid_b = v; in_data_b = d; end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? in_ready_a : in_ready_b;
  endfunction

  task automatic push_exp(input int sel, input logic [15:0] d, input logic last);
    exp_t e;
    e.data = d;
    e.last = last;
    if (sel == 0) exp_q_a.push_back(e);
    else          exp_q_b.push_back(e);
  endtask

  task automatic queue_empty(input int sel, input string name);
    check(name, (sel == 0) ? exp_q_a.size() : exp_q_b.size(), 0);
  endtask

  // Start a frame and stream its pixels; an expected result is queued as each
  // window's bottom-right pixel is driven. Returns after the done pulse.
  task automatic run_vec(input int v);
    int sel, n, nd, oc, k, li;
    sel = vecs[v].sel;
    n   = vecs[v].n_px;
    nd  = done_cnt[sel];
    oc  = out_cnt[sel];
    k   = 0;
    @(posedge clk); #1;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (vecs[v].duty < 100) begin
        while ($urandom_range(99) >= vecs[v].duty) begin
          set_in(sel, 1'b0, 16'h0);
          @(posedge clk); #1;
        end
      end
      li = i % 16;
      set_in(sel, 1'b1, vecs[v].px[i]);
      if (vecs[v].mid_start && i == 7) set_start(sel, 1'b1);
      if (((li / 4) % 2 == 1) && ((li % 4) % 2 == 1)) begin
        push_exp(sel, vecs[v].exp_o[k], i == n - 1);
        k++;
      end
      if (!get_ready(sel)) begin
        check($sformatf("in_ready during stream vec%0d px%0d", v, i), 0, 1);
        break;
      end
      @(posedge clk); #1;
      set_start(sel, 1'b0);
    end
    set_in(sel, 1'b0, 16'h0);
    for (int t = 0; t < 20 && done_cnt[sel] == nd; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("done count vec%0d", v), done_cnt[sel] - nd, 1);
    check($sformatf("done after out_last vec%0d", v), done_cyc[sel] - last_cyc[sel], 1);
    check($sformatf("output count vec%0d", v), out_cnt[sel] - oc, n / 4);
    queue_empty(sel, $sformatf("scoreboard drained vec%0d", v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, oc;
    rst_n = 1'b0;
    start_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
    start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
    for (int s = 0; s < 2; s++) begin
      done_cnt[s] = 0; done_cyc[s] = 0; last_cyc[s] = 0; out_cnt[s] = 0;
    end

    // v0: ramp 0..15; v1: signed window; v2: ramp with bubbles; v3: two
    // channels ramp then reversed; v4: ramp with start pulsed mid-frame;
    // v5: full-range extremes; v6: two identical ramps with bubbles.
    for (int v = 0; v < 7; v++) begin
      vecs[v].sel = 0; vecs[v].n_px = 16; vecs[v].duty = 100; vecs[v].mid_start = 1'b0;
      vecs[v].px = '0; vecs[v].exp_o = '0;
    end
    for (int i = 0; i < 16; i++) begin
      vecs[0].px[i] = 16'(i);
      vecs[1].px[i] = 16'hFF9C;
      vecs[2].px[i] = 16'(i);
      vecs[4].px[i] = 16'(i);
      vecs[5].px[i] = 16'h8000;
    end
    for (int i = 0; i < 32; i++) begin
      vecs[3].px[i] = (i < 16) ? 16'(i) : 16'(31 - i);
      vecs[6].px[i] = 16'(i % 16);
    end
    vecs[0].exp_o[3:0] = {16'd15, 16'd13, 16'd7, 16'd5};
    vecs[1].px[0] = 16'hFFFD; vecs[1].px[1] = 16'hFFFF;
    vecs[1].px[4] = 16'hFFF8; vecs[1].px[5] = 16'hFFFE;
    vecs[1].exp_o[3:0] = {16'hFF9C, 16'hFF9C, 16'hFF9C, 16'hFFFF};
    vecs[2].duty = 50;
    vecs[2].exp_o[3:0] = {16'd15, 16'd13, 16'd7, 16'd5};
    vecs[3].sel = 1; vecs[3].n_px = 32;
    vecs[3].exp_o = {16'd5, 16'd7, 16'd13, 16'd15, 16'd15, 16'd13, 16'd7, 16'd5};
    vecs[4].mid_start = 1'b1;
    vecs[4].exp_o[3:0] = {16'd15, 16'd13, 16'd7, 16'd5};
    vecs[5].px[5] = 16'h8001; vecs[5].px[10] = 16'h7FFF; vecs[5].px[15] = 16'h0000;
    vecs[5].exp_o[3:0] = {16'h7FFF, 16'h8000, 16'h8000, 16'h8001};
    vecs[6].sel = 1; vecs[6].n_px = 32; vecs[6].duty = 60;
    vecs[6].exp_o = {16'd15, 16'd13, 16'd7, 16'd5, 16'd15, 16'd13, 16'd7, 16'd5};

    #2;
    check("reset in_ready", int'(in_ready_a), 0);
    check("reset out_valid", int'(out_valid_a), 0);
    check("reset out_last", int'(out_last_a), 0);
    check("reset done", int'(done_a), 0);
    check("reset out_data", int'(out_data_a), 0);
    check("reset in_ready dut_b", int'(in_ready_b), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_vec(0);

    // in_valid while IDLE must not be consumed.
    oc = out_cnt[0];
    for (int t = 0; t < 8; t++) begin
      set_in(0, 1'b1, 16'(100 + t));
      @(posedge clk); #1;
    end
    set_in(0, 1'b0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check("outputs while idle", out_cnt[0] - oc, 0);
    check("in_ready while idle", int'(in_ready_a), 0);

    for (int v = 1; v < 7; v++) run_vec(v);

    // Reset after 9 transfers of the ramp.
    nd = done_cnt[0];
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_in(0, 1'b1, 16'(i));
      if (i == 5) push_exp(0, 16'd5, 1'b0);
      if (i == 7) push_exp(0, 16'd7, 1'b0);
      @(posedge clk); #1;
    end
    set_in(0, 1'b0, 16'h0);
    rst_n = 1'b0;
    #1;
    check("midframe reset in_ready", int'(in_ready_a), 0);
    check("midframe reset out_valid", int'(out_valid_a), 0);
    check("midframe reset out_last", int'(out_last_a), 0);
    check("midframe reset done", int'(done_a), 0);
    check("midframe reset out_data", int'(out_data_a), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no done after reset", done_cnt[0] - nd, 0);
    queue_empty(0, "scoreboard after reset");

    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
